rf_wb_arb: RTL and testbench

//  Write-side master for the integer register file. Merges single-cycle pipeline results (A) with

---
 rtl/rf_wb_arb.sv | 126 ++++++++++++
 tb/tb_rf_wb_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - register-file write-port arbiter merging pipeline (A) and long-latency (B) results
// B results are buffered in a FIFO; a pending scoreboard flags in-flight B destinations for decode.
module rf_wb_arb #(
    parameter int DW         = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [4:0]    a_rd,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [4:0]    b_rd,
    input  logic [DW-1:0] b_data,
    input  logic          iss_valid,
    input  logic [4:0]    iss_rd,
    input  logic [4:0]    chk_rs1,
    input  logic [4:0]    chk_rs2,
    output logic          hz1,
    output logic          hz2,
    output logic          wr_en,
    output logic [4:0]    rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [4:0]    mem_rd   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   pending;
    logic [31:0]   pending_nxt;

    logic          nonempty;
    logic          force_b;
    logic          sel_a;
    logic          pop;
    logic          push;
    logic [4:0]    head_rd;
    logic [DW-1:0] head_data;

    assign nonempty  = (count != '0);
    assign force_b   = nonempty && (starve_cnt == STARVE_C);
    assign a_ready   = !force_b;
    assign sel_a     = a_valid && a_ready;
    assign pop       = !sel_a && nonempty;
    assign b_ready   = (count < DEPTH_C);
    assign push      = b_valid && b_ready;
    assign head_rd   = mem_rd[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign hz1       = pending[chk_rs1];
    assign hz2       = pending[chk_rs2];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= b_rd;
            mem_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Count only consecutive A wins that actually bypassed a waiting B entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (pop || !nonempty || !a_valid) begin
            starve_cnt <= '0;
        end else if (sel_a && (starve_cnt != STARVE_C)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Clear first so a same-cycle issue to the popped rd keeps the bit set.
    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head_rd] = 1'b0;
        if (iss_valid) pending_nxt[iss_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (sel_a) begin
            wr_en   <= (a_rd != 5'd0);
            rd_addr <= a_rd;
            rd_data <= a_data;
        end else if (pop) begin
            wr_en   <= (head_rd != 5'd0);
            rd_addr <= head_rd;
            rd_data <= head_data;
        end else begin
            wr_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - randomized and directed bench for rf_wb_arb against a queue-based reference model
module tb_rf_wb_arb;

    localparam int DW         = 32;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid, iss_valid;
    logic [4:0]    a_rd, b_rd, iss_rd, chk_rs1, chk_rs2;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready, hz1, hz2, wr_en;
    logic [4:0]    rd_addr;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    rf_wb_arb #(.DW(DW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hz1(hz1), .hz2(hz2),
        .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    int            starve;
    bit            pend[32];
    logic          m_wr_en;
    logic [4:0]    m_rd_addr;
    logic [DW-1:0] m_rd_data;

    function automatic void model_reset();
        q.delete();
        starve = 0;
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        m_wr_en   = 1'b0;
        m_rd_addr = '0;
        m_rd_data = '0;
    endfunction

    function automatic bit m_a_ready();
        return !(q.size() != 0 && starve == STARVE_MAX);
    endfunction

    function automatic bit m_b_ready();
        return q.size() < DEPTH;
    endfunction

    function automatic logic [4:0] seq_rd(input int idx);
        return 5'((idx % 31) + 1);
    endfunction

    task automatic drive(input bit av, input logic [4:0] ard, input logic [DW-1:0] ad,
                         input bit bv, input logic [4:0] brd, input logic [DW-1:0] bd,
                         input bit iv, input logic [4:0] ird);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        iss_valid = iv; iss_rd = ird;
        #1;
    endtask

    // Reference: one clock of arbitration expressed over the model queue.
    task automatic advance();
        bit   ne, ar, br, sa, pp;
        ent_t h;
        ne = (q.size() != 0);
        ar = m_a_ready();
        br = m_b_ready();
        sa = a_valid && ar;
        pp = !sa && ne;
        if (sa) begin
            m_wr_en = (a_rd != 0); m_rd_addr = a_rd; m_rd_data = a_data;
        end else if (pp) begin
            h = q.pop_front();
            m_wr_en = (h.rd != 0); m_rd_addr = h.rd; m_rd_data = h.data;
            pend[h.rd] = 1'b0;
        end else begin
            m_wr_en = 1'b0;
        end
        if (pp || !ne || !a_valid) starve = 0;
        else if (sa && starve < STARVE_MAX) starve++;
        if (b_valid && br) q.push_back({b_rd, b_data});
        if (iss_valid && iss_rd != 0) pend[iss_rd] = 1'b1;
        pend[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk); #1;
        vectors++;
        if ({wr_en, rd_addr, rd_data} !== {1'b0, 5'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_outputs got %b/%0d/%h want 0/0/0", wr_en, rd_addr, rd_data);
        end
        vectors++;
        if ({a_ready, b_ready, hz1, hz2} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 1100", {a_ready, b_ready, hz1, hz2});
        end
        rst = 1'b0;
    endtask

    task automatic test_a_only();
        drive(1, 5'd5, 32'h11, 0, 0, 0, 0, 0);
        advance();
        vectors++;
        if ({wr_en, rd_addr, rd_data} !== {1'b1, 5'd5, 32'h11}) begin
            miscompares++;
            $display("FAIL a_only_write got %b/%0d/%h want 1/5/11", wr_en, rd_addr, rd_data);
        end
        drive(1, 5'd0, 32'h22, 0, 0, 0, 0, 0);
        advance();
        vectors++;
        if ({wr_en, rd_addr} !== {1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL a_only_x0 got %b/%0d want 0/0", wr_en, rd_addr);
        end
    endtask

    task automatic test_b_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd1, 32'h300 + i, 1, 5'(10 + i), 32'hB0 + i, 0, 0);
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b_drain_full got b_ready=%b want 0", b_ready);
        end
        for (int j = 0; j < 4; j++) begin
            advance();
            vectors++;
            if ({wr_en, rd_addr, rd_data} !== {1'b1, 5'(10 + j), 32'hB0 + j}) begin
                miscompares++;
                $display("FAIL b_drain_%0d got %b/%0d/%h want 1/%0d/%h",
                         j, wr_en, rd_addr, rd_data, 10 + j, 32'hB0 + j);
            end
            if (j == 0) begin
                vectors++;
                if (b_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b_drain_ready got b_ready=%b want 1", b_ready);
                end
            end
        end
    endtask

    task automatic test_starvation();
        drive(0, 0, 0, 1, 5'd20, 32'hBEEF, 0, 0);
        advance();
        for (int k = 0; k < 8; k++) begin
            drive(1, 5'd3, 32'hA0 + k, 0, 0, 0, 0, 0);
            vectors++;
            if (a_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL starve_a_ready_%0d got %b want 1", k, a_ready);
            end
            advance();
            vectors++;
            if ({wr_en, rd_addr, rd_data} !== {1'b1, 5'd3, 32'hA0 + k}) begin
                miscompares++;
                $display("FAIL starve_a_write_%0d got %b/%0d/%h want 1/3/%h",
                         k, wr_en, rd_addr, rd_data, 32'hA0 + k);
            end
        end
        drive(1, 5'd3, 32'hA8, 0, 0, 0, 0, 0);
        vectors++;
        if (a_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_forced got a_ready=%b want 0", a_ready);
        end
        advance();
        vectors++;
        if ({wr_en, rd_addr, rd_data} !== {1'b1, 5'd20, 32'hBEEF}) begin
            miscompares++;
            $display("FAIL starve_b_write got %b/%0d/%h want 1/20/beef", wr_en, rd_addr, rd_data);
        end
        advance();
        vectors++;
        if ({wr_en, rd_addr, rd_data} !== {1'b1, 5'd3, 32'hA8}) begin
            miscompares++;
            $display("FAIL starve_held_a got %b/%0d/%h want 1/3/a8", wr_en, rd_addr, rd_data);
        end
    endtask

    task automatic test_scoreboard();
        chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({hz1, hz2} !== 2'b10) begin
            miscompares++;
            $display("FAIL sb_set got hz1/hz2=%b%b want 10", hz1, hz2);
        end
        drive(0, 0, 0, 1, 5'd7, 32'h77, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        vectors++;
        if ({wr_en, rd_addr, hz1} !== {1'b1, 5'd7, 1'b0}) begin
            miscompares++;
            $display("FAIL sb_clear got wr_en=%b rd_addr=%0d hz1=%b want 1/7/0", wr_en, rd_addr, hz1);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
        advance();
        drive(0, 0, 0, 1, 5'd7, 32'h78, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({wr_en, rd_addr, hz1} !== {1'b1, 5'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL sb_set_wins got wr_en=%b rd_addr=%0d hz1=%b want 1/7/1", wr_en, rd_addr, hz1);
        end
    endtask

    task automatic test_push_pop();
        int pushed = 0;
        int written = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd2, 32'h500 + i, 1, seq_rd(pushed), 32'hC00 + pushed, 0, 0);
            advance();
            pushed++;
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(0, 0, 0, 1, seq_rd(pushed), 32'hC00 + pushed, 0, 0);
            vectors++;
            if (b_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL pp_count_%0d got b_ready=%b want 1", i, b_ready);
            end
            advance();
            pushed++;
            vectors++;
            if ({wr_en, rd_addr, rd_data} !== {1'b1, seq_rd(written), 32'hC00 + written}) begin
                miscompares++;
                $display("FAIL pp_order_%0d got %b/%0d/%h want 1/%0d/%h",
                         written, wr_en, rd_addr, rd_data, seq_rd(written), 32'hC00 + written);
            end
            written++;
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            advance();
            vectors++;
            if ({wr_en, rd_addr, rd_data} !== {1'b1, seq_rd(written), 32'hC00 + written}) begin
                miscompares++;
                $display("FAIL pp_drain_%0d got %b/%0d/%h want 1/%0d/%h",
                         written, wr_en, rd_addr, rd_data, seq_rd(written), 32'hC00 + written);
            end
            written++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            chk_rs1 = 5'($urandom_range(0, 31));
            chk_rs2 = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 99) < 70, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)));
            vectors++;
            if ({a_ready, b_ready, hz1, hz2} !== {m_a_ready(), m_b_ready(), pend[chk_rs1], pend[chk_rs2]}) begin
                miscompares++;
                $display("FAIL rand_comb_%0d got %b want %b", n, {a_ready, b_ready, hz1, hz2},
                         {m_a_ready(), m_b_ready(), pend[chk_rs1], pend[chk_rs2]});
            end
            advance();
            vectors++;
            if ({wr_en, rd_addr, rd_data} !== {m_wr_en, m_rd_addr, m_rd_data}) begin
                miscompares++;
                $display("FAIL rand_write_%0d got %b/%0d/%h want %b/%0d/%h",
                         n, wr_en, rd_addr, rd_data, m_wr_en, m_rd_addr, m_rd_data);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            advance();
        end
        for (int i = 0; i < 32; i++) pend[i] = pend[i];
        drive(1, 5'd4, 32'h41, 1, 5'd9, 32'h91, 1, 5'd9);
        advance();
        drive(1, 5'd4, 32'h42, 1, 5'd12, 32'h92, 1, 5'd12);
        advance();
        chk_rs1 = 5'd9; chk_rs2 = 5'd12;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if ({wr_en, b_ready, hz1, hz2} !== {1'b1, 1'b1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL arst_before got %b want 1111", {wr_en, b_ready, hz1, hz2});
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({wr_en, rd_addr, a_ready, b_ready, hz1, hz2} !== {1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL arst_immediate got wr_en=%b rd_addr=%0d flags=%b want 0/0/1100",
                     wr_en, rd_addr, {a_ready, b_ready, hz1, hz2});
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        vectors++;
        if (wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_fifo_discarded got wr_en=%b want 0", wr_en);
        end
        drive(1, 5'd4, 32'h99, 0, 0, 0, 0, 0);
        advance();
        vectors++;
        if ({wr_en, rd_addr, rd_data} !== {1'b1, 5'd4, 32'h99}) begin
            miscompares++;
            $display("FAIL arst_resume got %b/%0d/%h want 1/4/99", wr_en, rd_addr, rd_data);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_a_only();
        test_b_drain();
        test_starvation();
        test_scoreboard();
        test_push_pop();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
